// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and controller-side signals of the memory arbiter
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_rdy;
  logic [31:0] if_data;
  logic        mem_req;
  logic [1:0]  mem_op;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rdy;
  logic [31:0] mem_rdata;
  logic        ctl_valid;
  logic [1:0]  ctl_op;
  logic [1:0]  ctl_len;
  logic [31:0] ctl_addr;
  logic [31:0] ctl_data;
  logic        ctl_done;
  logic [31:0] ctl_rdata;
  modport slave (
    input  if_req, if_addr, mem_req, mem_op, mem_len, mem_addr, mem_wdata, ctl_done, ctl_rdata,
    output if_rdy, if_data, mem_rdy, mem_rdata, ctl_valid, ctl_op, ctl_len, ctl_addr, ctl_data
  );
  modport master (
    output if_req, if_addr, mem_req, mem_op, mem_len, mem_addr, mem_wdata, ctl_done, ctl_rdata,
    input  if_rdy, if_data, mem_rdy, mem_rdata, ctl_valid, ctl_op, ctl_len, ctl_addr, ctl_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the memory controller request port between instruction fetch and load/store
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W = 3
) (
  input logic clk_in,
  input logic rst_in,
  input logic rdy_in,
  input logic take_jmp,
  mem_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, GNT_IF, GNT_MEM, DRAIN, RESP} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] starve, starve_n;
  logic mem_vld, gnt_if, gnt_mem, busy, if_done, mem_done;
  assign mem_vld = bus.mem_req && bus.mem_op != 2'b00;
  assign busy = state == GNT_IF || state == GNT_MEM || state == DRAIN;
  assign if_done = state == GNT_IF && bus.ctl_done && !take_jmp;
  assign mem_done = state == GNT_MEM && bus.ctl_done;
  // Arbitration in IDLE (MEM first unless IF has been starved) and transaction sequencing
  always_comb begin
    state_n = state;
    starve_n = starve;
    gnt_if = 1'b0;
    gnt_mem = 1'b0;
    case (state)
      IDLE: begin
        gnt_mem = mem_vld && (!bus.if_req || starve < CNT_W'(STARVE_LIMIT));
        gnt_if = !gnt_mem && bus.if_req && !take_jmp;
        state_n = gnt_mem ? GNT_MEM : gnt_if ? GNT_IF : IDLE;
        starve_n = (gnt_mem && bus.if_req) ? starve + 1'b1 : (bus.if_req && !gnt_if) ? starve : '0;
      end
      GNT_IF: state_n = bus.ctl_done ? RESP : take_jmp ? DRAIN : GNT_IF;
      GNT_MEM, DRAIN: state_n = bus.ctl_done ? RESP : state;
      default: state_n = IDLE;
    endcase
  end
  // State and starvation counter; everything freezes while rdy_in is low
  always_ff @(posedge clk_in)
    if (rst_in) begin
      state <= IDLE;
      starve <= '0;
    end else if (rdy_in) begin
      state <= state_n;
      starve <= starve_n;
    end
  // Controller request latch and completion routing back to the owning requester
  always_ff @(posedge clk_in)
    if (rst_in) begin
      bus.if_rdy <= 1'b0;
      bus.if_data <= '0;
      bus.mem_rdy <= 1'b0;
      bus.mem_rdata <= '0;
      bus.ctl_valid <= 1'b0;
      bus.ctl_op <= 2'b00;
      bus.ctl_len <= 2'b00;
      bus.ctl_addr <= '0;
      bus.ctl_data <= '0;
    end else if (rdy_in) begin
      bus.if_rdy <= if_done;
      bus.mem_rdy <= mem_done;
      if (if_done) bus.if_data <= bus.ctl_rdata;
      if (mem_done) bus.mem_rdata <= bus.ctl_rdata;
      if (gnt_if || gnt_mem) begin
        bus.ctl_valid <= 1'b1;
        bus.ctl_op <= gnt_mem ? bus.mem_op : 2'b01;
        bus.ctl_len <= gnt_mem ? bus.mem_len : 2'b11;
        bus.ctl_addr <= gnt_mem ? bus.mem_addr : bus.if_addr;
        bus.ctl_data <= gnt_mem ? bus.mem_wdata : '0;
      end else if (busy && bus.ctl_done) bus.ctl_valid <= 1'b0;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam logic [31:0] S_IDLE = 0, S_GNT_IF = 1, S_GNT_MEM = 2, S_DRAIN = 3, S_RESP = 4;
  logic clk_in, rst_in, rdy_in, take_jmp;
  int vectors, miscompares;
  mem_arbiter_if bus();
  mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .take_jmp(take_jmp),
    .bus(bus)
  );
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    logic [31:0] a;
    vectors = 0;
    miscompares = 0;
    rst_in = 1'b1;
    rdy_in = 1'b1;
    take_jmp = 1'b0;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.mem_req = 1'b0;
    bus.mem_op = 2'b00;
    bus.mem_len = 2'b00;
    bus.mem_addr = '0;
    bus.mem_wdata = '0;
    bus.ctl_done = 1'b0;
    bus.ctl_rdata = '0;
    tick();
    tick();
    rst_in = 1'b0;
    chk("rst_ctl_valid", bus.ctl_valid, 0);
    chk("rst_ctl_op", bus.ctl_op, 0);
    chk("rst_ctl_addr", bus.ctl_addr, 0);
    chk("rst_if_rdy", bus.if_rdy, 0);
    chk("rst_mem_rdy", bus.mem_rdy, 0);
    chk("rst_state", dut.state, S_IDLE);
    chk("rst_starve", dut.starve, 0);
    // IF only: word fetch, controller answers three cycles after ctl_valid
    bus.if_req = 1'b1;
    bus.if_addr = 32'h1000;
    tick();
    chk("if_valid", bus.ctl_valid, 1);
    chk("if_op", bus.ctl_op, 2'b01);
    chk("if_len", bus.ctl_len, 2'b11);
    chk("if_addr", bus.ctl_addr, 32'h1000);
    chk("if_data0", bus.ctl_data, 0);
    tick();
    tick();
    chk("if_hold_valid", bus.ctl_valid, 1);
    tick();
    bus.ctl_done = 1'b1;
    bus.ctl_rdata = 32'h00000013;
    tick();
    bus.ctl_done = 1'b0;
    bus.if_req = 1'b0;
    chk("if_rdy", bus.if_rdy, 1);
    chk("if_rdata", bus.if_data, 32'h00000013);
    chk("if_valid_drop", bus.ctl_valid, 0);
    chk("if_state_resp", dut.state, S_RESP);
    tick();
    chk("if_rdy_single", bus.if_rdy, 0);
    chk("if_state_idle", dut.state, S_IDLE);
    // Simultaneous IF and MEM SAVE: MEM wins, IF follows two cycles after mem_rdy
    bus.if_req = 1'b1;
    bus.if_addr = 32'h2000;
    bus.mem_req = 1'b1;
    bus.mem_op = 2'b10;
    bus.mem_len = 2'b11;
    bus.mem_addr = 32'h30004;
    bus.mem_wdata = 32'hDEADBEEF;
    tick();
    chk("sim_mem_op", bus.ctl_op, 2'b10);
    chk("sim_mem_addr", bus.ctl_addr, 32'h30004);
    chk("sim_mem_wdata", bus.ctl_data, 32'hDEADBEEF);
    chk("sim_starve", dut.starve, 1);
    bus.ctl_done = 1'b1;
    bus.ctl_rdata = 32'h0;
    tick();
    bus.ctl_done = 1'b0;
    bus.mem_req = 1'b0;
    chk("sim_mem_rdy", bus.mem_rdy, 1);
    chk("sim_if_rdy0", bus.if_rdy, 0);
    tick();
    chk("sim_gap_valid", bus.ctl_valid, 0);
    chk("sim_gap_mem_rdy", bus.mem_rdy, 0);
    tick();
    chk("sim_if_valid", bus.ctl_valid, 1);
    chk("sim_if_addr", bus.ctl_addr, 32'h2000);
    chk("sim_if_op", bus.ctl_op, 2'b01);
    bus.ctl_done = 1'b1;
    bus.ctl_rdata = 32'hCAFEF00D;
    tick();
    bus.ctl_done = 1'b0;
    bus.if_req = 1'b0;
    chk("sim_if_rdy", bus.if_rdy, 1);
    chk("sim_if_data", bus.if_data, 32'hCAFEF00D);
    tick();
    // Starvation: four MEM grants, then IF forced through, then MEM resumes
    bus.if_req = 1'b1;
    bus.if_addr = 32'h6000;
    bus.mem_req = 1'b1;
    bus.mem_op = 2'b01;
    bus.mem_len = 2'b00;
    bus.mem_addr = 32'h100;
    tick();
    for (int i = 0; i < 4; i++) begin
      a = 32'h100 + 32'(i) * 4;
      chk("stv_mem_valid", bus.ctl_valid, 1);
      chk("stv_mem_addr", bus.ctl_addr, a);
      chk("stv_starve", dut.starve, 32'(i + 1));
      bus.ctl_done = 1'b1;
      bus.ctl_rdata = 32'(i) + 32'h50;
      tick();
      chk("stv_mem_rdy", bus.mem_rdy, 1);
      chk("stv_mem_rdata", bus.mem_rdata, 32'(i) + 32'h50);
      bus.ctl_done = 1'b0;
      bus.mem_addr = bus.mem_addr + 32'd4;
      tick();
      tick();
    end
    chk("stv_if_addr", bus.ctl_addr, 32'h6000);
    chk("stv_if_op", bus.ctl_op, 2'b01);
    chk("stv_if_starve0", dut.starve, 0);
    bus.ctl_done = 1'b1;
    bus.ctl_rdata = 32'h77;
    tick();
    chk("stv_if_rdy", bus.if_rdy, 1);
    chk("stv_if_data", bus.if_data, 32'h77);
    bus.ctl_done = 1'b0;
    bus.if_req = 1'b0;
    tick();
    tick();
    chk("stv_resume_valid", bus.ctl_valid, 1);
    chk("stv_resume_addr", bus.ctl_addr, 32'h110);
    chk("stv_resume_starve", dut.starve, 0);
    bus.ctl_done = 1'b1;
    tick();
    chk("stv_resume_rdy", bus.mem_rdy, 1);
    bus.ctl_done = 1'b0;
    bus.mem_req = 1'b0;
    tick();
    tick();
    // Jump right after an IF grant: drain the controller, drop the result
    bus.if_req = 1'b1;
    bus.if_addr = 32'h4000;
    tick();
    chk("jmp_grant_addr", bus.ctl_addr, 32'h4000);
    take_jmp = 1'b1;
    bus.if_req = 1'b0;
    tick();
    take_jmp = 1'b0;
    chk("jmp_state_drain", dut.state, S_DRAIN);
    chk("jmp_valid_held", bus.ctl_valid, 1);
    tick();
    chk("jmp_valid_held2", bus.ctl_valid, 1);
    bus.ctl_done = 1'b1;
    bus.ctl_rdata = 32'hBAD0BAD0;
    tick();
    bus.ctl_done = 1'b0;
    chk("jmp_no_if_rdy", bus.if_rdy, 0);
    chk("jmp_valid_drop", bus.ctl_valid, 0);
    chk("jmp_state_resp", dut.state, S_RESP);
    tick();
    chk("jmp_no_if_rdy2", bus.if_rdy, 0);
    bus.if_req = 1'b1;
    bus.if_addr = 32'h5000;
    tick();
    chk("jmp_next_addr", bus.ctl_addr, 32'h5000);
    chk("jmp_next_valid", bus.ctl_valid, 1);
    bus.ctl_done = 1'b1;
    bus.ctl_rdata = 32'h12345678;
    tick();
    bus.ctl_done = 1'b0;
    bus.if_req = 1'b0;
    chk("jmp_next_rdy", bus.if_rdy, 1);
    chk("jmp_next_data", bus.if_data, 32'h12345678);
    tick();
    // Jump in the same cycle as ctl_done, and a jump blocking an IF grant in IDLE
    bus.if_req = 1'b1;
    bus.if_addr = 32'h7000;
    take_jmp = 1'b1;
    tick();
    chk("jmp_idle_nogrant", bus.ctl_valid, 0);
    take_jmp = 1'b0;
    tick();
    chk("jmp_done_grant", bus.ctl_addr, 32'h7000);
    take_jmp = 1'b1;
    bus.if_req = 1'b0;
    bus.ctl_done = 1'b1;
    tick();
    take_jmp = 1'b0;
    bus.ctl_done = 1'b0;
    chk("jmp_done_no_rdy", bus.if_rdy, 0);
    chk("jmp_done_valid", bus.ctl_valid, 0);
    tick();
    // MEM request with NOP op is never granted
    bus.mem_req = 1'b1;
    bus.mem_op = 2'b00;
    tick();
    tick();
    chk("nop_ignored", bus.ctl_valid, 0);
    // rdy_in low freezes everything even with ctl_done high
    bus.mem_op = 2'b01;
    bus.mem_len = 2'b01;
    bus.mem_addr = 32'h100;
    tick();
    chk("frz_grant", bus.ctl_valid, 1);
    chk("frz_len", bus.ctl_len, 2'b01);
    rdy_in = 1'b0;
    bus.ctl_done = 1'b1;
    bus.ctl_rdata = 32'h1234;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("frz_no_rdy", bus.mem_rdy, 0);
      chk("frz_state", dut.state, S_GNT_MEM);
    end
    rdy_in = 1'b1;
    bus.ctl_done = 1'b0;
    tick();
    chk("frz_still_valid", bus.ctl_valid, 1);
    chk("frz_still_no_rdy", bus.mem_rdy, 0);
    bus.ctl_done = 1'b1;
    tick();
    bus.ctl_done = 1'b0;
    bus.mem_req = 1'b0;
    chk("frz_rdy", bus.mem_rdy, 1);
    chk("frz_rdata", bus.mem_rdata, 32'h1234);
    tick();
    tick();
    // Reset during a MEM grant
    bus.if_req = 1'b1;
    bus.if_addr = 32'h8000;
    bus.mem_req = 1'b1;
    bus.mem_addr = 32'h200;
    tick();
    chk("rst_mid_grant", bus.ctl_addr, 32'h200);
    chk("rst_mid_starve1", dut.starve, 1);
    rst_in = 1'b1;
    bus.ctl_done = 1'b1;
    tick();
    rst_in = 1'b0;
    bus.ctl_done = 1'b0;
    bus.if_req = 1'b0;
    bus.mem_req = 1'b0;
    chk("rst_mid_valid", bus.ctl_valid, 0);
    chk("rst_mid_mem_rdy", bus.mem_rdy, 0);
    chk("rst_mid_op", bus.ctl_op, 0);
    chk("rst_mid_state", dut.state, S_IDLE);
    chk("rst_mid_starve", dut.starve, 0);
    tick();
    chk("rst_mid_no_resp", bus.mem_rdy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single request port of the byte-serial memory controller between the instruction-fetch requester (IF) and the load/store requester (MEM).
- Holds one granted transaction at a time, routes the controller's completion back to the owner, and discards IF results invalidated by a jump.
- MEM has fixed priority. A starvation counter guarantees IF forward progress.

Parameters:
- STARVE_LIMIT, 4, consecutive MEM grants allowed while IF is pending before IF is forced through
- CNT_W, 3, width of starvation counter (must hold STARVE_LIMIT)

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; low freezes all state
- take_jmp  input  1  pipeline flush; cancels pending/in-flight IF
- if_req  input  1  IF request, level, held until if_rdy
- if_addr  input  32  fetch address (always word load)
- if_rdy  output  1  one-cycle completion pulse to IF
- if_data  output  32  fetched word, valid with if_rdy
- mem_req  input  1  MEM request, level, held until mem_rdy
- mem_op  input  2  00 NOP, 01 LOAD, 10 SAVE
- mem_len  input  2  00 BYTE, 01 HALF, 11 WORD
- mem_addr  input  32  byte address
- mem_wdata  input  32  store data, LSB-aligned
- mem_rdy  output  1  one-cycle completion pulse to MEM
- mem_rdata  output  32  load result, valid with mem_rdy
- ctl_valid  output  1  request to controller, held until ctl_done
- ctl_op  output  2  op to controller
- ctl_len  output  2  length to controller
- ctl_addr  output  32  address to controller
- ctl_data  output  32  store data to controller
- ctl_done  input  1  controller completion pulse
- ctl_rdata  input  32  controller result, valid with ctl_done

Behaviour:
- Reset: state IDLE, starve count 0. if_rdy, mem_rdy, ctl_valid = 0. ctl_op = NOP. All data/address outputs 0.
- rdy_in = 0: no register changes, including when take_jmp or ctl_done is high. The controller is frozen by the same signal.
- States:
  - IDLE
  - GNT_IF
  - GNT_MEM
  - DRAIN: IF grant cancelled; waits for ctl_done
  - RESP: one-cycle gap so the requester can drop its req
- IDLE arbitration, evaluated each cycle:
  - A MEM request counts only when mem_req = 1 and mem_op != NOP. mem_req with op NOP is ignored and never acknowledged.
  - MEM request and (IF not pending or starve < STARVE_LIMIT) -> GNT_MEM. If IF is pending, starve += 1.
  - Else if IF pending and take_jmp = 0 -> GNT_IF, starve = 0.
  - IF not pending -> starve = 0.
- Grant latency: request sampled in IDLE at cycle N -> ctl_valid = 1 with latched op/len/addr/data at N+1.
  - IF grant drives op LOAD, len WORD, data 0.
  - Fields stay stable until ctl_done.
- Completion: ctl_done at cycle M in GNT_x -> ctl_valid = 0 and the matching rdy = 1 with data = ctl_rdata at M+1. State is RESP at M+1 and IDLE at M+2. Next grant no earlier than ctl_valid at M+3.
- mem_rdata on SAVE: passes ctl_rdata unchanged; no meaning.
- take_jmp in GNT_IF before ctl_done -> DRAIN. ctl_valid stays high because the controller must finish the byte sequence.
- In DRAIN, ctl_done -> RESP with if_rdy held 0 and the data dropped.
- take_jmp in the same cycle as ctl_done while in GNT_IF -> result dropped, no if_rdy.
- take_jmp in RESP after if_rdy -> no effect.
- take_jmp never affects GNT_MEM, DRAIN, or a MEM request.
- ctl_done outside GNT_IF, GNT_MEM, or DRAIN is ignored.
- Rdy pulses last exactly one cycle; never two consecutive.
- Reset mid-transaction: immediate return to IDLE with all outputs at reset values. No response is delivered.

Test Plan:
- IF only, if_addr=0x1000, controller returns 0x00000013 three cycles after ctl_valid -> ctl_op=01, ctl_len=11, ctl_addr=0x1000. if_rdy pulse with if_data=0x00000013 one cycle after ctl_done.
- Simultaneous IF 0x2000 and MEM SAVE addr 0x30004, data 0xDEADBEEF, len WORD -> MEM granted first with ctl_data=0xDEADBEEF. mem_rdy pulse. IF granted next, ctl_valid rising exactly 2 cycles after mem_rdy.
- MEM_req held continuously with new ops, IF pending, STARVE_LIMIT=4 -> exactly 4 MEM grants, then one IF grant, then MEM resumes.
- take_jmp one cycle after IF grant at 0x4000 -> ctl_valid held until ctl_done. if_rdy never asserts. Next IF request 0x5000 granted normally.
- rdy_in low for 5 cycles while ctl_done is high -> no state change or pulse. Completion is taken once rdy_in returns and the controller re-signals.
- rst_in asserted in GNT_MEM -> next cycle ctl_valid=0, mem_rdy=0, state IDLE, starve=0.
